// File: rtl/afe_l2_wr_arbiter.sv
// -----------------------------------------------------------------------------
// afe_l2_wr_arbiter
//
// Shares the single L2 write port among NUM_CH AFE readout channels. Each cycle
// the write slot is free, one eligible channel is picked round-robin, its sample
// is popped (ch_ready_o doubles as that channel's address-generator transfer
// strobe) and a registered TCDM-style write is issued with lane-replicated data
// and byte enables derived from the sample size and low address bits.
//
// Optional feature: define AFE_ARB_PRIO_EN to add cfg_ch_prio_i. Eligible
// channels with prio=1 are then served round-robin before any prio=0 channel,
// sharing the single rr pointer.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   cfg_ch_en_i         per-channel arbitration enable
//   cfg_ch_prio_i       per-channel high priority (AFE_ARB_PRIO_EN only)
//   ch_valid_i          channel has a sample ready
//   ch_data_i           per-channel sample, right-aligned
//   ch_datasize_i       per-channel size: 00 byte, 01 half, 1x word
//   ch_addr_i           per-channel current byte address
//   ch_ready_o          one-hot pop / transfer-valid
//   l2_req_o, l2_gnt_i  write request / grant
//   l2_addr_o           word-aligned address
//   l2_wdata_o          lane-replicated write data
//   l2_be_o             byte enables
//   l2_wen_o            constant 0 (write)
//   busy_o              request outstanding
// -----------------------------------------------------------------------------
module afe_l2_wr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned AWIDTH = 18,
    parameter int unsigned DWIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        cfg_ch_en_i,
`ifdef AFE_ARB_PRIO_EN
    input  logic [NUM_CH-1:0]        cfg_ch_prio_i,
`endif
    input  logic [NUM_CH-1:0]        ch_valid_i,
    input  logic [NUM_CH*DWIDTH-1:0] ch_data_i,
    input  logic [NUM_CH*2-1:0]      ch_datasize_i,
    input  logic [NUM_CH*AWIDTH-1:0] ch_addr_i,
    output logic [NUM_CH-1:0]        ch_ready_o,
    output logic                     l2_req_o,
    input  logic                     l2_gnt_i,
    output logic [AWIDTH-1:0]        l2_addr_o,
    output logic [DWIDTH-1:0]        l2_wdata_o,
    output logic [3:0]               l2_be_o,
    output logic                     l2_wen_o,
    output logic                     busy_o
);

    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              r_req;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [3:0]        r_be;
    logic [PW-1:0]     r_rr_ptr;

    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_cand;
    logic              w_slot_free;
    logic              w_found;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_ptr_nxt;
    int unsigned       w_idx;
    logic              w_pop;
    logic [DWIDTH-1:0] w_sel_data;
    logic [1:0]        w_sel_size;
    logic [AWIDTH-1:0] w_sel_addr;
    logic [DWIDTH-1:0] w_wdata;
    logic [3:0]        w_be;

    assign w_slot_free = ~r_req | l2_gnt_i;
    assign w_elig      = ch_valid_i & cfg_ch_en_i;

`ifdef AFE_ARB_PRIO_EN
    // High-priority subset wins outright whenever it is non-empty.
    logic [NUM_CH-1:0] w_hi;
    assign w_hi   = w_elig & cfg_ch_prio_i;
    assign w_cand = (|w_hi) ? w_hi : w_elig;
`else
    assign w_cand = w_elig;
`endif

    // Cyclic search starting at the rr pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_idx = 32'(r_rr_ptr) + k;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (!w_found && w_cand[PW'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
    end

    assign w_ptr_nxt  = (32'(w_win) == NUM_CH - 1) ? '0 : w_win + 1'b1;
    assign w_pop      = w_slot_free & w_found;
    assign ch_ready_o = w_pop ? (NUM_CH'(1) << w_win) : '0;

    assign w_sel_data = ch_data_i[DWIDTH*w_win +: DWIDTH];
    assign w_sel_size = ch_datasize_i[2*w_win +: 2];
    assign w_sel_addr = ch_addr_i[AWIDTH*w_win +: AWIDTH];

    // Replicate the sample across every lane so only byte enables select it.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = w_sel_data;
        case (w_sel_size)
            2'b00: begin
                w_be    = 4'b0001 << w_sel_addr[1:0];
                w_wdata = {(DWIDTH/8){w_sel_data[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {w_sel_addr[1], 1'b0};
                w_wdata = {(DWIDTH/16){w_sel_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = w_sel_data;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rr_ptr <= '0;
        end else if (w_pop) begin
            r_req    <= 1'b1;
            r_addr   <= {w_sel_addr[AWIDTH-1:2], 2'b00};
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_rr_ptr <= w_ptr_nxt;
        end else if (l2_gnt_i) begin
            r_req <= 1'b0;
        end
    end

    assign l2_req_o   = r_req;
    assign l2_addr_o  = r_addr;
    assign l2_wdata_o = r_wdata;
    assign l2_be_o    = r_be;
    assign l2_wen_o   = 1'b0;
    assign busy_o     = r_req;

endmodule

// File: doc/afe_l2_wr_arbiter.md
Name: afe_l2_wr_arbiter

Overview:
- Shares the single L2 write port among NUM_CH AFE readout channels, each of which has its own channel buffer and L2 address generator.
- Picks one requesting channel per cycle by round-robin and pops its sample.
- Issues a registered TCDM-style write (req/gnt) carrying the channel's current address, lane-aligned data and byte enables.
- Its pop pulse also acts as the transfer-valid strobe for that channel's address generator.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
AWIDTH, 18, L2 byte-address width
DWIDTH, 32, L2 data width (fixed 32; byte enables are 4 bits)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
cfg_ch_en_i  in  NUM_CH  per-channel arbitration enable
ch_valid_i  in  NUM_CH  channel has a sample ready
ch_data_i  in  NUM_CH*32  sample, right-aligned
ch_datasize_i  in  NUM_CH*2  00 byte, 01 half, 10/11 word
ch_addr_i  in  NUM_CH*AWIDTH  current address from the channel's address generator
ch_ready_o  out  NUM_CH  one-hot pop; also the address generator's transfer-valid
l2_req_o  out  1  write request
l2_gnt_i  in  1  grant
l2_addr_o  out  AWIDTH  word-aligned address (low 2 bits zero)
l2_wdata_o  out  32  lane-replicated data
l2_be_o  out  4  byte enables
l2_wen_o  out  1  constant 0 (write)
busy_o  out  1  l2_req_o asserted

Behaviour:
- Reset values: l2_req_o=0, l2_addr_o=0, l2_wdata_o=0, l2_be_o=0, ch_ready_o=0, busy_o=0, rr pointer=0. l2_wen_o is always 0.
- Slot free = ~req_q | l2_gnt_i.
- Eligible set = ch_valid_i & cfg_ch_en_i.
- When the slot is free and the eligible set is non-empty, the winner is the first eligible channel at or after the rr pointer, searching cyclically.
- ch_ready_o[winner]=1 combinationally in the same cycle. The rr pointer becomes winner+1, mod NUM_CH. No pop occurs when the slot is not free.
- Capture on pop into the output registers:
  - l2_addr_o = {addr[AWIDTH-1:2],2'b00}.
  - Byte: be = 4'b0001<<addr[1:0]; wdata = {4{data[7:0]}}.
  - Half: be = 4'b0011<<{addr[1],1'b0}; wdata = {2{data[15:0]}}.
  - Word: be = 4'b1111; wdata = data.
- req_q is set on pop and is visible at the next cycle. Latency from ch_valid_i to l2_req_o is 1 cycle.
- Pending request:
  - Address, data and be stay stable while l2_req_o=1 and l2_gnt_i=0.
  - A request is never retracted.
  - Grant with a new pop in the same cycle gives back-to-back requests, so throughput is 1 write per cycle.
  - Grant with no eligible channel clears req_q at the next cycle.
- Disable: cfg_ch_en_i going low stops new pops from that channel. A request already captured from it still completes.
- Valid dropping after a pop has no effect, because the data is already captured.
- Reset mid-transfer: the pending request is dropped immediately (async). The L2 side must tolerate this.
- Single-channel eligibility: the same channel wins every free cycle.
- All eligible: strict rotation 0,1,...,NUM_CH-1,0.

Optional Feature:
- Macro AFE_ARB_PRIO_EN adds input cfg_ch_prio_i[NUM_CH].
- With the macro: eligible channels with prio=1 are arbitrated round-robin among themselves and always before prio=0 channels. One shared rr pointer is used, updated to winner+1.
- Without the macro: the port does not exist and arbitration is plain round-robin.

Test Plan:
- Reset, then all channels idle: l2_req_o=0, ch_ready_o=0. Assert rst_i during a pending request: l2_req_o drops to 0 immediately.
- NUM_CH=4, all valid and enabled, l2_gnt_i=1 constantly: pops are one-hot in order 0,1,2,3,0; l2_req_o stays high every cycle after the first.
- ch1 byte write, data 0xA5, addr 0x00103: l2_addr_o=0x00100, l2_be_o=1000, l2_wdata_o=0xA5A5A5A5. Half write at addr 0x00102, data 0x1234: be=1100, wdata=0x12341234.
- Hold l2_gnt_i=0 for 5 cycles with ch0 and ch2 valid: one pop only; addr/data/be stable; no further ch_ready_o until the grant; the next winner is ch2.
- cfg_ch_en_i=4'b1011 with all valid: channel 2 never popped; rotation 0,1,3.
- AFE_ARB_PRIO_EN, prio=4'b0100, all valid, gnt=1: ch2 wins every cycle. Then set prio=0: rotation resumes at ch3.
